// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg : shared types, width constant and op-class helpers for the
//              iterative RV32M multiply/divide unit
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic is_rem(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  function automatic logic a_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic b_signed(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic returns_high(input muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_if.sv
// ---------------------------------------------------------------------------
// alu_muldiv_if : start/done request bus between execute stage and muldiv unit
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_muldiv_if;
  import muldiv_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, op, rd1, rd2, input busy, done, result);
  modport slave  (input start, op, rd1, rd2, output busy, done, result);

endinterface

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ---------------------------------------------------------------------------
// alu_muldiv : 32-iteration shift-add multiplier / restoring divider (RV32M)
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_muldiv
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  alu_muldiv_if.slave  bus
);

  muldiv_state_t     state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  muldiv_op_t        op_q, op_d;
  logic              neg_q, neg_d;    // negate product / quotient
  logic              rneg_q, rneg_d;  // negate remainder (dividend sign)
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  muldiv_op_t        op_in;
  logic              a_neg, b_neg, accept, div0, sub;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     add_a, add_b;
  logic [XLEN+1:0]   add_sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign op_in  = muldiv_op_t'(bus.op);
  assign a_neg  = a_signed(op_in) & bus.rd1[XLEN-1];
  assign b_neg  = b_signed(op_in) & bus.rd2[XLEN-1];
  assign a_mag  = a_neg ? -bus.rd1 : bus.rd1;
  assign b_mag  = b_neg ? -bus.rd2 : bus.rd2;
  assign accept = bus.start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign div0   = is_div(op_in) & (bus.rd2 == '0);

  // One adder serves both: product-high + multiplicand, or remainder - divisor.
  // For the subtract, carry-out high means the trial subtraction did not borrow.
  assign sub     = is_div(op_q);
  assign add_a   = sub ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
  assign add_b   = {1'b0, opnd_q};
  assign add_sum = {1'b0, add_a} + {1'b0, sub ? ~add_b : add_b}
                 + {{(XLEN+1){1'b0}}, sub};

  assign prod_fix = neg_q  ? -acc_q : acc_q;
  assign quot_fix = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (sub) begin
          if (add_sum[XLEN+1])
            acc_d = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else
            acc_d = {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
          if (acc_q[0])
            acc_d = {add_sum[XLEN:0], acc_q[XLEN-1:1]};
          else
            acc_d = {1'b0, acc_q[2*XLEN-1:1]};
        end
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        if (is_div(op_q))
          result_d = is_rem(op_q) ? rem_fix : quot_fix;
        else
          result_d = returns_high(op_q) ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
      end
      default: begin
        if (accept) begin
          op_d  = op_in;
          cnt_d = 5'd0;
          neg_d = a_neg ^ b_neg;
          if (is_div(op_in)) begin
            rneg_d = a_neg;
            acc_d  = {{XLEN{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            rneg_d = 1'b0;
            acc_d  = {{XLEN{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          if (div0) begin
            state_d  = ST_DONE;
            result_d = is_rem(op_in) ? bus.rd1 : {XLEN{1'b1}};
          end else begin
            state_d  = ST_CALC;
          end
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == ST_CALC) | (state_q == ST_FIX);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv : vector table plus hand sequences for the muldiv unit
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_muldiv;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  alu_muldiv_if bus();
  alu_muldiv dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 20;
  vec_t        vecs[NV];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request; latency counts the accept edge's cycle as 1.
  task automatic run_req(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int poke_at,
                         input string name);
    int k = 0;
    int busy_cnt = 0;
    logic [31:0] want;
    sb.push_back(exp);
    bus.op    = op;
    bus.rd1   = a;
    bus.rd2   = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && k < 60) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (k == poke_at) begin
        bus.op    = OP_MULHU;
        bus.rd1   = 32'hFFFF_FFFF;
        bus.rd2   = 32'hFFFF_FFFF;
        bus.start = 1'b1;
      end
      tick();
      k++;
      bus.start = 1'b0;
    end
    want = sb.pop_front();
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done after %0d cycles, required %0d", name, k, lat);
    end else begin
      check({name, " result"}, bus.result, want);
      check({name, " latency"}, k + 1, lat);
      check({name, " busy cycles"}, busy_cnt, (lat == 1) ? 0 : 33);
    end
  endtask

  initial begin
    int seen_done;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        34};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         34};
    vecs[8]  = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
    vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34};
    vecs[12] = '{OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{OP_REMU,   32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 1};
    vecs[14] = '{OP_MULHU,  32'h8000_0000,  32'd2,         32'd1,         34};
    vecs[15] = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         34};
    vecs[16] = '{OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         34};
    vecs[17] = '{OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[18] = '{OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         34};
    vecs[19] = '{OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34};

    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.rd1   = '0;
    bus.rd2   = '0;
    n_rst     = 1'b0;
    #12;
    check("reset busy",   {31'd0, bus.busy}, 32'd0);
    check("reset done",   {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result,        32'd0);
    #10 n_rst = 1'b1;
    tick();

    // Consecutive vectors also exercise acceptance from the DONE state.
    for (int i = 0; i < NV; i++)
      run_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, -1,
              $sformatf("vec%0d", i));

    tick();
    check("done pulse width", {31'd0, bus.done}, 32'd0);
    check("result held",      bus.result,        vecs[NV-1].exp);

    run_req(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 5, "start mid-CALC ignored");

    run_req(OP_REMU, 32'd100, 32'd7, 32'd2, 34, -1, "b2b first");
    check("b2b in DONE", {31'd0, bus.done}, 32'd1);
    run_req(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, -1, "b2b second");

    bus.op    = OP_DIVU;
    bus.rd1   = 32'hFFFF_FFFF;
    bus.rd2   = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    check("abort busy before", {31'd0, bus.busy}, 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check("abort busy",   {31'd0, bus.busy}, 32'd0);
    check("abort done",   {31'd0, bus.done}, 32'd0);
    check("abort result", bus.result,        32'd0);
    #2 n_rst = 1'b1;
    seen_done = 0;
    repeat (40) begin
      tick();
      if (bus.done === 1'b1) seen_done = 1;
    end
    check("aborted no done", seen_done, 0);
    run_req(OP_DIVU, 32'd9, 32'd3, 32'd3, 34, -1, "post-reset DIVU");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
